// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU field widths, extract helpers and unpacked result type
package fpu_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS = 127;
  typedef struct packed {
    logic sign;
    logic [EXP_W:0] exp9;
    logic [MAN_W-1:0] man;
  } res_t;
  function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] v);
    return v[30:23];
  endfunction
  function automatic logic [MAN_W-1:0] f_man(input logic [31:0] v);
    return v[22:0];
  endfunction
  // exp9[8] marks underflow or overflow past 255: flush to signed zero
  function automatic logic [31:0] pack(input res_t r);
    return r.exp9[EXP_W] ? {r.sign, 31'b0} : {r.sign, r.exp9[EXP_W-1:0], r.man};
  endfunction
endpackage

// File: rtl/lzc25.sv
// lzc25: 25-bit leading-zero count, all-zero input gives 255
module lzc25 (
  input  logic [24:0] d,
  output logic [7:0]  z
);
  always_comb begin
    z = 8'd255;
    for (int i = 0; i < 25; i++) if (d[i]) z = 8'(24 - i);
  end
endmodule

// File: rtl/fsub_pipe.sv
// fsub_pipe: 3-stage elastic single-precision subtractor, y = x1 - x2, truncating
module fsub_pipe
  import fpu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic [TAG_W-1:0] out_tag
);
  logic s1_v, s1_sign, s1_sub;
  logic [7:0] s1_el;
  logic [24:0] s1_big, s1_sm;
  logic [TAG_W-1:0] s1_tag;
  logic s2_v, s2_sign, s2_sub;
  logic [7:0] s2_el, s2_lzc;
  logic [25:0] s2_r;
  logic [TAG_W-1:0] s2_tag;
  logic s2_adv, s3_adv;
  assign s3_adv = !out_valid | out_ready;
  assign s2_adv = !s2_v | s3_adv;
  assign in_ready = !s1_v | s2_adv;
  // S1: order operands by magnitude so the aligned difference is never negative
  logic gt;
  logic [31:0] x2n, l_op, s_op;
  logic [7:0] de;
  assign gt = x1[30:0] > x2[30:0];
  assign x2n = {~x2[31], x2[30:0]};
  assign l_op = gt ? x1 : x2n;
  assign s_op = gt ? x2n : x1;
  assign de = f_exp(l_op) - f_exp(s_op);
  // S2
  logic [25:0] r_d;
  logic [7:0] lzc_d;
  assign r_d = s1_sub ? {1'b0, s1_big - s1_sm} : {1'b0, s1_big} + {1'b0, s1_sm};
  lzc25 u_lzc (.d(r_d[24:0]), .z(lzc_d));
  // S3: bit 24 of norm is the hidden one, bit 0 the truncated guard
  logic [24:0] norm;
  res_t res;
  logic unused;
  assign norm = s2_r[24:0] << s2_lzc;
  assign unused = ^{norm[24], norm[0]};
  always_comb begin
    res.sign = s2_sign;
    res.exp9 = s2_sub ? {1'b0, s2_el} - {1'b0, s2_lzc} : {1'b0, s2_el} + {8'b0, s2_r[25]};
    res.man = s2_sub ? norm[23:1] : s2_r[25] ? s2_r[24:2] : s2_r[23:1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      out_valid <= 1'b0;
      y <= '0;
      out_tag <= '0;
    end else begin
      if (in_ready) s1_v <= in_valid;
      if (s2_adv) s2_v <= s1_v;
      if (s3_adv) out_valid <= s2_v;
      if (in_ready && in_valid) begin
        s1_sign <= l_op[31];
        s1_sub <= l_op[31] ^ s_op[31];
        s1_el <= f_exp(l_op);
        s1_big <= {1'b1, f_man(l_op), 1'b0};
        s1_sm <= {1'b1, f_man(s_op), 1'b0} >> de;
        s1_tag <= in_tag;
      end
      if (s2_adv && s1_v) begin
        s2_sign <= s1_sign;
        s2_sub <= s1_sub;
        s2_el <= s1_el;
        s2_r <= r_d;
        s2_lzc <= lzc_d;
        s2_tag <= s1_tag;
      end
      if (s3_adv && s2_v) begin
        y <= pack(res);
        out_tag <= s2_tag;
      end
    end
  end
endmodule
